// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access size, completion status, FSM state.
// No logic of its own beyond a size-to-byte-count helper.
// Imported by the lane aligner and the AXI sequencing top.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } mem_size_t;

  typedef enum logic [1:0] {
    ERR_OK       = 2'd0,
    ERR_MISALIGN = 2'd1,
    ERR_BUSERR   = 2'd2
  } lsu_err_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_RESP = 3'd4,
    ST_RESP    = 3'd5
  } lsu_state_t;

  // Number of bytes touched by an access of the given size.
  function automatic logic [3:0] size_bytes(input mem_size_t sz);
    return 4'd1 << sz;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store data/strobe shift up to the lane offset, load data shift down and extend.
// Latency: purely combinational.
// Backpressure: none, no handshake of its own.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int NB  = XLEN / 8,
  localparam int OW  = $clog2(NB)
) (
  input  logic [OW-1:0]   off_i,
  input  mem_size_t       size_i,
  input  logic            unsigned_i,
  input  logic [XLEN-1:0] st_data_i,
  output logic [XLEN-1:0] st_data_o,
  output logic [NB-1:0]   st_strb_o,
  input  logic [XLEN-1:0] ld_data_i,
  output logic [XLEN-1:0] ld_data_o
);

  logic [3:0]      nbytes;
  logic [NB-1:0]   size_strb;
  logic [XLEN-1:0] lane_mask;
  logic [XLEN-1:0] ld_shift;
  logic            sign_bit;

  // Shift store lanes up, load lanes down, then mask and sign/zero fill above the access width.
  always_comb begin
    nbytes    = size_bytes(size_i);
    size_strb = '0;
    lane_mask = '0;
    for (int i = 0; i < NB; i++) begin
      size_strb[i]         = (i < int'(nbytes));
      lane_mask[8*i +: 8]  = {8{size_strb[i]}};
    end
    st_strb_o = size_strb << off_i;
    st_data_o = st_data_i << {off_i, 3'b000};
    ld_shift  = ld_data_i >> {off_i, 3'b000};
    case (size_i)
      SZ_B:    sign_bit = ld_shift[7];
      SZ_H:    sign_bit = ld_shift[15];
      SZ_W:    sign_bit = ld_shift[31];
      default: sign_bit = ld_shift[XLEN-1];
    endcase
    if (unsigned_i) sign_bit = 1'b0;
    ld_data_o = (ld_shift & lane_mask) | ({XLEN{sign_bit}} & ~lane_mask);
  end

endmodule

// File: rtl/lsu_axi_master.sv
// Runs one core load/store as an AXI4-Lite master transaction with lane steering and error reporting.
// Latency: min load accept->resp_valid 3 cycles; misaligned requests complete after 1 cycle with no bus traffic.
// Backpressure: req_ready only in IDLE; AXI valids held until ready; resp_valid is a one-cycle pulse, not stallable.
module lsu_axi_master
  import lsu_pkg::*;
#(
  parameter int          XLEN   = 32,
  parameter int          ADDR_W = 32,
  parameter logic [2:0]  AXPROT = 3'b000,
  localparam int         NB     = XLEN / 8,
  localparam int         OW     = $clog2(NB)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_data,
  output logic [1:0]        resp_err,
  output logic [ADDR_W-1:0] axi_araddr,
  output logic              axi_arvalid,
  output logic [2:0]        axi_arprot,
  input  logic              axi_arready,
  input  logic [XLEN-1:0]   axi_rdata,
  input  logic [1:0]        axi_rresp,
  input  logic              axi_rvalid,
  output logic              axi_rready,
  output logic [ADDR_W-1:0] axi_awaddr,
  output logic              axi_awvalid,
  output logic [2:0]        axi_awprot,
  input  logic              axi_awready,
  output logic [XLEN-1:0]   axi_wdata,
  output logic [NB-1:0]     axi_wstrb,
  output logic              axi_wvalid,
  input  logic              axi_wready,
  input  logic [1:0]        axi_bresp,
  input  logic              axi_bvalid,
  output logic              axi_bready
);

  lsu_state_t        state_q, state_d;
  logic [OW-1:0]     off_q, off_d;
  mem_size_t         size_q, size_d;
  logic              uns_q, uns_d;
  logic              arvalid_q, arvalid_d, rready_q, rready_d;
  logic              awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d, awaddr_q, awaddr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d, rsp_data_q, rsp_data_d;
  logic [NB-1:0]     wstrb_q, wstrb_d;
  logic              rsp_vld_q, rsp_vld_d;
  lsu_err_t          rsp_err_q, rsp_err_d;

  mem_size_t         req_sz;
  logic [OW-1:0]     req_off;
  logic [ADDR_W-1:0] req_addr_al;
  logic              misalign;
  logic [OW-1:0]     la_off;
  mem_size_t         la_size;
  logic              la_uns;
  logic [XLEN-1:0]   la_st_data, la_ld_data;
  logic [NB-1:0]     la_st_strb;

  assign req_sz      = mem_size_t'(req_size);
  assign req_off     = req_addr[OW-1:0];
  assign req_addr_al = {req_addr[ADDR_W-1:OW], {OW{1'b0}}};

  // Offset must be a multiple of the access width; doubleword only exists on a 64-bit datapath.
  always_comb begin
    case (req_sz)
      SZ_B:    misalign = 1'b0;
      SZ_H:    misalign = req_off[0];
      SZ_W:    misalign = (req_off[1:0] != 2'b00);
      default: misalign = (XLEN != 64) || (req_off != '0);
    endcase
  end

  // The aligner sees live request fields while idle (store lanes are captured at accept)
  // and the latched fields afterwards (load extraction on R).
  assign la_off  = (state_q == ST_IDLE) ? req_off      : off_q;
  assign la_size = (state_q == ST_IDLE) ? req_sz       : size_q;
  assign la_uns  = (state_q == ST_IDLE) ? req_unsigned : uns_q;

  lsu_lane_align #(.XLEN(XLEN)) u_align (
    .off_i      (la_off),
    .size_i     (la_size),
    .unsigned_i (la_uns),
    .st_data_i  (req_wdata),
    .st_data_o  (la_st_data),
    .st_strb_o  (la_st_strb),
    .ld_data_i  (axi_rdata),
    .ld_data_o  (la_ld_data)
  );

  // Next-state and next register values for the transaction sequencer.
  always_comb begin
    state_d    = state_q;
    off_d      = off_q;
    size_d     = size_q;
    uns_d      = uns_q;
    arvalid_d  = arvalid_q;
    araddr_d   = araddr_q;
    rready_d   = rready_q;
    awvalid_d  = awvalid_q;
    awaddr_d   = awaddr_q;
    wvalid_d   = wvalid_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bready_d   = bready_q;
    rsp_vld_d  = 1'b0;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          off_d  = req_off;
          size_d = req_sz;
          uns_d  = req_unsigned;
          if (misalign) begin
            rsp_vld_d  = 1'b1;
            rsp_data_d = '0;
            rsp_err_d  = ERR_MISALIGN;
            state_d    = ST_RESP;
          end else if (req_we) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            awaddr_d  = req_addr_al;
            wdata_d   = la_st_data;
            wstrb_d   = la_st_strb;
            state_d   = ST_WR_REQ;
          end else begin
            arvalid_d = 1'b1;
            araddr_d  = req_addr_al;
            state_d   = ST_RD_ADDR;
          end
        end
      end
      ST_RD_ADDR: begin
        if (axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RD_DATA;
        end
      end
      ST_RD_DATA: begin
        if (axi_rvalid) begin
          rready_d  = 1'b0;
          rsp_vld_d = 1'b1;
          if (axi_rresp != 2'b00) begin
            rsp_err_d  = ERR_BUSERR;
            rsp_data_d = '0;
          end else begin
            rsp_err_d  = ERR_OK;
            rsp_data_d = la_ld_data;
          end
          state_d = ST_RESP;
        end
      end
      ST_WR_REQ: begin
        if (awvalid_q && axi_awready) awvalid_d = 1'b0;
        if (wvalid_q && axi_wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = ST_WR_RESP;
        end
      end
      ST_WR_RESP: begin
        if (axi_bvalid) begin
          bready_d   = 1'b0;
          rsp_vld_d  = 1'b1;
          rsp_data_d = '0;
          rsp_err_d  = (axi_bresp != 2'b00) ? ERR_BUSERR : ERR_OK;
          state_d    = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and all bus-facing registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      off_q      <= '0;
      size_q     <= SZ_B;
      uns_q      <= 1'b0;
      arvalid_q  <= 1'b0;
      araddr_q   <= '0;
      rready_q   <= 1'b0;
      awvalid_q  <= 1'b0;
      awaddr_q   <= '0;
      wvalid_q   <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bready_q   <= 1'b0;
      rsp_vld_q  <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= ERR_OK;
    end else begin
      state_q    <= state_d;
      off_q      <= off_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      arvalid_q  <= arvalid_d;
      araddr_q   <= araddr_d;
      rready_q   <= rready_d;
      awvalid_q  <= awvalid_d;
      awaddr_q   <= awaddr_d;
      wvalid_q   <= wvalid_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bready_q   <= bready_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign resp_valid  = rsp_vld_q;
  assign resp_data   = rsp_data_q;
  assign resp_err    = rsp_err_q;
  assign axi_araddr  = araddr_q;
  assign axi_arvalid = arvalid_q;
  assign axi_arprot  = AXPROT;
  assign axi_rready  = rready_q;
  assign axi_awaddr  = awaddr_q;
  assign axi_awvalid = awvalid_q;
  assign axi_awprot  = AXPROT;
  assign axi_wdata   = wdata_q;
  assign axi_wstrb   = wstrb_q;
  assign axi_wvalid  = wvalid_q;
  assign axi_bready  = bready_q;

endmodule

// File: tb/tb_lsu_axi_master.sv
// Directed bench for lsu_axi_master: a 32-bit instance for lane/extension/error/timing cases
// and a 64-bit instance for doubleword stores, upper-word loads and reset while a write is pending.
// Outputs are sampled 1 ns after the rising edge; stimulus is driven at the same point.
module tb_lsu_axi_master;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // 32-bit instance
  logic        req_valid = 0, req_ready, req_we = 0, req_unsigned = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic [1:0]  req_size = 0;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [1:0]  resp_err;
  logic [31:0] araddr, awaddr, wdata, rdata = 0;
  logic        arvalid, arready = 0, rvalid = 0, rready;
  logic        awvalid, awready = 0, wvalid, wready = 0, bvalid = 0, bready;
  logic [2:0]  arprot, awprot;
  logic [1:0]  rresp = 0, bresp = 0;
  logic [3:0]  wstrb;

  lsu_axi_master #(.XLEN(32), .ADDR_W(32), .AXPROT(3'b000)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .axi_araddr(araddr), .axi_arvalid(arvalid), .axi_arprot(arprot), .axi_arready(arready),
    .axi_rdata(rdata), .axi_rresp(rresp), .axi_rvalid(rvalid), .axi_rready(rready),
    .axi_awaddr(awaddr), .axi_awvalid(awvalid), .axi_awprot(awprot), .axi_awready(awready),
    .axi_wdata(wdata), .axi_wstrb(wstrb), .axi_wvalid(wvalid), .axi_wready(wready),
    .axi_bresp(bresp), .axi_bvalid(bvalid), .axi_bready(bready)
  );

  // 64-bit instance
  logic        d_req_valid = 0, d_req_ready, d_req_we = 0, d_req_unsigned = 0;
  logic [31:0] d_req_addr = 0, d_araddr, d_awaddr;
  logic [63:0] d_req_wdata = 0, d_resp_data, d_rdata = 0, d_wdata;
  logic [1:0]  d_req_size = 0, d_resp_err, d_rresp = 0, d_bresp = 0;
  logic        d_resp_valid, d_arvalid, d_arready = 0, d_rvalid = 0, d_rready;
  logic        d_awvalid, d_awready = 0, d_wvalid, d_wready = 0, d_bvalid = 0, d_bready;
  logic [2:0]  d_arprot, d_awprot;
  logic [7:0]  d_wstrb;

  lsu_axi_master #(.XLEN(64), .ADDR_W(32), .AXPROT(3'b000)) dut64 (
    .clk(clk), .rstn(rstn),
    .req_valid(d_req_valid), .req_ready(d_req_ready), .req_we(d_req_we), .req_addr(d_req_addr),
    .req_size(d_req_size), .req_unsigned(d_req_unsigned), .req_wdata(d_req_wdata),
    .resp_valid(d_resp_valid), .resp_data(d_resp_data), .resp_err(d_resp_err),
    .axi_araddr(d_araddr), .axi_arvalid(d_arvalid), .axi_arprot(d_arprot), .axi_arready(d_arready),
    .axi_rdata(d_rdata), .axi_rresp(d_rresp), .axi_rvalid(d_rvalid), .axi_rready(d_rready),
    .axi_awaddr(d_awaddr), .axi_awvalid(d_awvalid), .axi_awprot(d_awprot), .axi_awready(d_awready),
    .axi_wdata(d_wdata), .axi_wstrb(d_wstrb), .axi_wvalid(d_wvalid), .axi_wready(d_wready),
    .axi_bresp(d_bresp), .axi_bvalid(d_bvalid), .axi_bready(d_bready)
  );

  // Load with immediate arready/rvalid: checks the N+1/N+2/N+3 timing and the extracted result.
  task automatic run_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                          input logic uns, input logic [31:0] rd, input logic [1:0] rr,
                          input logic [31:0] exp_araddr, input logic [31:0] exp_data,
                          input logic [1:0] exp_err);
    @(negedge clk);
    req_valid = 1; req_we = 0; req_addr = addr; req_size = size; req_unsigned = uns;
    arready = 1;
    cyc();
    req_valid = 0;
    chk({tag, "/busy"},    64'(req_ready), 64'd0);
    chk({tag, "/arvalid"}, 64'(arvalid),   64'd1);
    chk({tag, "/araddr"},  64'(araddr),    64'(exp_araddr));
    cyc();
    chk({tag, "/ar_drop"}, 64'(arvalid),   64'd0);
    chk({tag, "/rready"},  64'(rready),    64'd1);
    rvalid = 1; rdata = rd; rresp = rr;
    cyc();
    rvalid = 0; arready = 0; rresp = 0;
    chk({tag, "/resp_vld"}, 64'(resp_valid), 64'd1);
    chk({tag, "/data"},     64'(resp_data),  64'(exp_data));
    chk({tag, "/err"},      64'(resp_err),   64'(exp_err));
    chk({tag, "/r_drop"},   64'(rready),     64'd0);
    cyc();
    chk({tag, "/pulse"},    64'(resp_valid), 64'd0);
    chk({tag, "/idle"},     64'(req_ready),  64'd1);
  endtask

  // Store with awready/wready rising after the given delays (cycles after accept).
  task automatic run_store(input string tag, input logic [31:0] addr, input logic [1:0] size,
                           input logic [31:0] wd, input logic [1:0] br, input int aw_dly,
                           input int w_dly, input logic [31:0] exp_awaddr, input logic [3:0] exp_strb,
                           input logic [31:0] exp_wdata, input logic [1:0] exp_err);
    int b_cyc, r_cyc, hs;
    logic [31:0] got_data;
    logic [1:0]  got_err;
    b_cyc = -1; r_cyc = -1; got_data = 'x; got_err = 'x;
    hs = (aw_dly > w_dly) ? aw_dly : w_dly;
    @(negedge clk);
    req_valid = 1; req_we = 1; req_addr = addr; req_size = size; req_wdata = wd;
    cyc();
    req_valid = 0; req_we = 0;
    chk({tag, "/awvalid"}, 64'(awvalid), 64'd1);
    chk({tag, "/wvalid"},  64'(wvalid),  64'd1);
    chk({tag, "/awaddr"},  64'(awaddr),  64'(exp_awaddr));
    chk({tag, "/wstrb"},   64'(wstrb),   64'(exp_strb));
    chk({tag, "/wdata"},   64'(wdata),   64'(exp_wdata));
    chk({tag, "/no_ar"},   64'(arvalid), 64'd0);
    for (int c = 0; c < 30; c++) begin
      if (resp_valid) begin
        r_cyc = c; got_data = resp_data; got_err = resp_err;
        break;
      end
      if (aw_dly < w_dly && c == aw_dly + 1) begin
        chk({tag, "/aw_only_drop"}, 64'({awvalid, wvalid}), 64'b01);
      end
      if (bready && b_cyc < 0) begin
        b_cyc = c; bvalid = 1; bresp = br;
      end
      awready = (c >= aw_dly);
      wready  = (c >= w_dly);
      cyc();
      bvalid = 0;
    end
    awready = 0; wready = 0; bresp = 0;
    chk({tag, "/bready_cyc"}, 64'(b_cyc),   64'(hs + 1));
    chk({tag, "/resp_cyc"},   64'(r_cyc),   64'(hs + 2));
    chk({tag, "/data"},       64'(got_data), 64'd0);
    chk({tag, "/err"},        64'(got_err),  64'(exp_err));
    cyc();
    chk({tag, "/pulse"},    64'(resp_valid), 64'd0);
    chk({tag, "/err_hold"}, 64'(resp_err),   64'(exp_err));
    chk({tag, "/idle"},     64'(req_ready),  64'd1);
  endtask

  initial begin
    #1;
    chk("rst/req_ready",  64'(req_ready),  64'd1);
    chk("rst/resp",       64'({resp_valid, resp_data, resp_err}), 64'd0);
    chk("rst/valids",     64'({arvalid, rready, awvalid, wvalid, bready}), 64'd0);
    chk("rst/payload",    64'({araddr, wstrb}), 64'd0);
    chk("rst/awaddr",     64'(awaddr), 64'd0);
    chk("rst/wdata",      64'(wdata),  64'd0);
    chk("rst64/ready",    64'(d_req_ready), 64'd1);
    chk("rst64/valids",   64'({d_arvalid, d_awvalid, d_wvalid, d_wstrb}), 64'd0);
    repeat (2) @(negedge clk);
    rstn = 1;

    run_load("lw",   32'h104, 2'd2, 1'b0, 32'hDEADBEEF, 2'b00, 32'h104, 32'hDEADBEEF, 2'd0);
    run_load("lb",   32'h103, 2'd0, 1'b0, 32'h80112233, 2'b00, 32'h100, 32'hFFFFFF80, 2'd0);
    run_load("lbu",  32'h103, 2'd0, 1'b1, 32'h80112233, 2'b00, 32'h100, 32'h00000080, 2'd0);
    run_load("lhu",  32'h102, 2'd1, 1'b1, 32'h80112233, 2'b00, 32'h100, 32'h00008011, 2'd0);
    run_load("lh",   32'h102, 2'd1, 1'b0, 32'h80112233, 2'b00, 32'h100, 32'hFFFF8011, 2'd0);
    run_load("lbu1", 32'h101, 2'd0, 1'b1, 32'h80112233, 2'b00, 32'h100, 32'h00000022, 2'd0);
    run_load("lw_berr", 32'h108, 2'd2, 1'b0, 32'h12345678, 2'b10, 32'h108, 32'h0, 2'd2);

    run_store("sb",      32'h201, 2'd0, 32'h000000AB, 2'b00, 0, 3, 32'h200, 4'b0010, 32'h0000AB00, 2'd0);
    run_store("sh",      32'h202, 2'd1, 32'h0000BEEF, 2'b00, 0, 0, 32'h200, 4'b1100, 32'hBEEF0000, 2'd0);
    run_store("sw_berr", 32'h300, 2'd2, 32'h12345678, 2'b11, 2, 0, 32'h300, 4'b1111, 32'h12345678, 2'd2);

    // Misaligned halfword store: completes next cycle with no bus activity.
    @(negedge clk);
    req_valid = 1; req_we = 1; req_addr = 32'h103; req_size = 2'd1; req_wdata = 32'h1234;
    cyc();
    req_valid = 0; req_we = 0;
    chk("mis/resp_vld", 64'(resp_valid), 64'd1);
    chk("mis/err",      64'(resp_err),   64'd1);
    chk("mis/data",     64'(resp_data),  64'd0);
    chk("mis/no_bus",   64'({arvalid, awvalid, wvalid}), 64'd0);
    cyc();
    chk("mis/pulse",    64'(resp_valid), 64'd0);
    chk("mis/no_bus2",  64'({arvalid, awvalid, wvalid}), 64'd0);
    chk("mis/idle",     64'(req_ready),  64'd1);
    // Doubleword on a 32-bit datapath is illegal even when aligned.
    @(negedge clk);
    req_valid = 1; req_we = 0; req_addr = 32'h100; req_size = 2'd3;
    cyc();
    req_valid = 0;
    chk("d32/err",      64'(resp_err),   64'd1);
    chk("d32/no_ar",    64'(arvalid),    64'd0);
    cyc();

    // 64-bit: SD at 0x8, both readies immediate.
    @(negedge clk);
    d_req_valid = 1; d_req_we = 1; d_req_addr = 32'h8; d_req_size = 2'd3;
    d_req_wdata = 64'h1122334455667788; d_awready = 1; d_wready = 1;
    cyc();
    d_req_valid = 0; d_req_we = 0;
    chk("sd/awaddr", 64'(d_awaddr), 64'h8);
    chk("sd/wstrb",  64'(d_wstrb),  64'hFF);
    chk("sd/wdata",  d_wdata,       64'h1122334455667788);
    cyc();
    d_awready = 0; d_wready = 0;
    chk("sd/bready", 64'({d_awvalid, d_wvalid, d_bready}), 64'b001);
    d_bvalid = 1;
    cyc();
    d_bvalid = 0;
    chk("sd/resp", 64'({d_resp_valid, d_resp_err}), 64'b100);
    cyc();

    // 64-bit: signed word load from upper half.
    @(negedge clk);
    d_req_valid = 1; d_req_addr = 32'hC; d_req_size = 2'd2; d_req_unsigned = 0; d_arready = 1;
    cyc();
    d_req_valid = 0;
    chk("lw64/araddr", 64'(d_araddr), 64'h8);
    cyc();
    d_arready = 0; d_rvalid = 1; d_rdata = 64'h89ABCDEF00000000;
    cyc();
    d_rvalid = 0;
    chk("lw64/vld",  64'(d_resp_valid), 64'd1);
    chk("lw64/data", d_resp_data,       64'hFFFFFFFF89ABCDEF);
    cyc();

    // 64-bit: reset while stuck in WR_REQ.
    @(negedge clk);
    d_req_valid = 1; d_req_we = 1; d_req_addr = 32'h10; d_req_size = 2'd3; d_req_wdata = 64'h5;
    cyc();
    d_req_valid = 0; d_req_we = 0;
    cyc();
    chk("rstmid/pending", 64'({d_awvalid, d_wvalid, d_req_ready}), 64'b110);
    #2 rstn = 0;
    #1;
    chk("rstmid/valids",  64'({d_awvalid, d_wvalid, d_bready}), 64'd0);
    chk("rstmid/ready",   64'(d_req_ready), 64'd1);
    chk("rstmid/resp",    64'(d_resp_valid), 64'd0);
    @(negedge clk);
    rstn = 1;

    run_load("lw_after_rst", 32'h40, 2'd2, 1'b1, 32'hCAFEF00D, 2'b00, 32'h40, 32'hCAFEF00D, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
